// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - MIO bus responder: wait-stated RAM plus LED/SW/timer IO registers
// Optional feature: define MIO_TIMER_EN to build the free-running timer at IO offset 2.
module mio_bus_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        CPU_MIO,
   input  logic        mem_w,
   input  logic [31:0] Addr_in,
   input  logic [31:0] Data_wr,
   output logic [31:0] Data_rd,
   output logic        MIO_ready,
   input  logic [15:0] sw,
   output logic [15:0] led,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t              state, state_nxt;
   logic [3:0]          cnt, cnt_nxt;

   logic                cap_we;
   logic                cap_io;
   logic [1:0]          cap_off;
   logic [ADDR_W-1:0]   cap_idx;
   logic [31:0]         cap_data;

   logic                acc_fire;
   logic                acc_we;
   logic                acc_io;
   logic [1:0]          acc_off;
   logic [ADDR_W-1:0]   acc_idx;
   logic [31:0]         acc_data;
   logic [31:0]         io_rd;
   logic [31:0]         ram_rd;
   logic [31:0]         timer_rd;

   logic [31:0]         ram [0:(1<<ADDR_W)-1];

   // Aliased high address bits and the byte offset never take part in decode.
   logic                unused_addr;
   assign unused_addr = ^{Addr_in[27:ADDR_W+2], Addr_in[1:0]};

   // Next state, wait counter and the access strobe; with zero wait states
   // the access uses the live request on the capture edge.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      acc_fire  = 1'b0;
      if (state == S_IDLE) begin
         acc_we   = mem_w;
         acc_io   = (Addr_in[31:28] == 4'hF);
         acc_off  = Addr_in[3:2];
         acc_idx  = Addr_in[ADDR_W+1:2];
         acc_data = Data_wr;
      end else begin
         acc_we   = cap_we;
         acc_io   = cap_io;
         acc_off  = cap_off;
         acc_idx  = cap_idx;
         acc_data = cap_data;
      end
      case (state)
         S_IDLE: begin
            if (CPU_MIO) begin
               if (WAIT_LD == 4'd0) begin
                  state_nxt = S_ACK;
                  acc_fire  = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WAIT_LD;
               end
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               state_nxt = S_ACK;
               acc_fire  = 1'b1;
            end
         end
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign MIO_ready = (state == S_ACK);
   assign busy      = (state != S_IDLE);

   // Read data selection for the access in progress.
   always_comb begin
      ram_rd = ram[acc_idx];
      case (acc_off)
         2'd0:    io_rd = {16'h0, led};
         2'd1:    io_rd = {16'h0, sw};
         2'd2:    io_rd = timer_rd;
         default: io_rd = 32'h0;
      endcase
   end

   // State register, counter and request capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         cap_we   <= 1'b0;
         cap_io   <= 1'b0;
         cap_off  <= 2'd0;
         cap_idx  <= '0;
         cap_data <= 32'h0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == S_IDLE && CPU_MIO) begin
            cap_we   <= mem_w;
            cap_io   <= (Addr_in[31:28] == 4'hF);
            cap_off  <= Addr_in[3:2];
            cap_idx  <= Addr_in[ADDR_W+1:2];
            cap_data <= Data_wr;
         end
      end
   end

   // Read data and LED register updates on the access edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Data_rd <= 32'h0;
         led     <= 16'h0;
      end else if (acc_fire) begin
         if (!acc_we)
            Data_rd <= acc_io ? io_rd : ram_rd;
         else if (acc_io && acc_off == 2'd0)
            led <= acc_data[15:0];
      end
   end

   // RAM write port; the reset guard keeps an aborted request from landing.
   always_ff @(posedge clk) begin
      if (!reset && acc_fire && acc_we && !acc_io)
         ram[acc_idx] <= acc_data;
   end

`ifdef MIO_TIMER_EN
   logic [31:0] timer;

   // Free-running timer; a bus write wins over the increment for one edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         timer <= 32'h0;
      else if (acc_fire && acc_we && acc_io && acc_off == 2'd2)
         timer <= acc_data;
      else
         timer <= timer + 32'd1;
   end

   assign timer_rd = timer;
`else
   assign timer_rd = 32'h0;
`endif

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb/tb_mio_bus_responder.sv - self-checking bench for mio_bus_responder (2 and 0 wait states)
module tb_mio_bus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] sw;

   logic        cpu, we, rdy, bsy;
   logic [31:0] addr, wd, rd;
   logic [15:0] led;

   logic        cpu0, we0, rdy0, bsy0;
   logic [31:0] addr0, wd0, rd0;
   logic [15:0] led0;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   logic [31:0] mem_m [int];
   logic [15:0] led_m;
   logic [31:0] last_rd;
   int          pool [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mio_bus_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset), .CPU_MIO(cpu), .mem_w(we), .Addr_in(addr),
      .Data_wr(wd), .Data_rd(rd), .MIO_ready(rdy), .sw(sw), .led(led), .busy(bsy)
   );

   mio_bus_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .CPU_MIO(cpu0), .mem_w(we0), .Addr_in(addr0),
      .Data_wr(wd0), .Data_rd(rd0), .MIO_ready(rdy0), .sw(sw), .led(led0), .busy(bsy0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus transaction; returns read data and latency seen in the ACK cycle
   // plus the index of the access edge. Inputs are scrambled after capture.
   task automatic txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] r, output int lat, output int unsigned acc_edge);
      @(negedge clk);
      check("idle_busy", {31'h0, sel ? bsy0 : bsy}, 32'h0);
      if (sel) begin cpu0 = 1'b1; we0 = w; addr0 = a; wd0 = d; end
      else     begin cpu  = 1'b1; we  = w; addr  = a; wd  = d; end
      @(posedge clk);
      #1;
      if (sel) begin addr0 = $urandom; wd0 = $urandom; we0 = ~w; end
      else     begin addr  = $urandom; wd  = $urandom; we  = ~w; end
      lat = 0; r = 'x; acc_edge = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) check("busy_after_capture", {31'h0, sel ? bsy0 : bsy}, 32'h1);
         if ((sel ? rdy0 : rdy) === 1'b1) begin
            lat = k; r = sel ? rd0 : rd; acc_edge = cyc;
            break;
         end
      end
      if (sel) cpu0 = 1'b0; else cpu = 1'b0;
      check("ack_seen", {31'h0, lat != 0}, 32'h1);
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:28] == 4'hF) begin
         case (a[3:2])
            2'd0:    return {16'h0, led_m};
            2'd1:    return {16'h0, sw};
            default: return 32'h0;
         endcase
      end
      return mem_m[int'(a[11:2])];
   endfunction

   // Transaction on the 2-wait-state DUT checked against the model.
   task automatic m_txn(input bit w, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] r, exp;
      int          lat;
      int unsigned e;
      exp = w ? last_rd : model_read(a);
      txn(1'b0, w, a, d, r, lat, e);
      check("latency", 32'(lat), 32'd3);
      check(w ? "rd_hold_on_write" : "read_data", r, exp);
      if (w) begin
         if (a[31:28] == 4'hF) begin
            if (a[3:2] == 2'd0) led_m = d[15:0];
         end else
            mem_m[int'(a[11:2])] = d;
      end else
         last_rd = exp;
      check("led", {16'h0, led}, {16'h0, led_m});
   endtask

   initial begin
      logic [31:0] r, r2, a, d;
      int          lat;
      int unsigned e1, e2;
      int          op, idx;

      reset = 1'b1; sw = 16'h0;
      cpu = 0; we = 0; addr = 0; wd = 0;
      cpu0 = 0; we0 = 0; addr0 = 0; wd0 = 0;
      led_m = 16'h0; last_rd = 32'h0;
      for (int i = 0; i < 8; i++) pool[i] = $urandom_range(0, 1023);
      pool[0] = 16;
      repeat (2) @(negedge clk);
      check("reset_ready", {31'h0, rdy}, 32'h0);
      check("reset_rd", rd, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0);
      check("reset_busy", {31'h0, bsy}, 32'h0);
      reset = 1'b0;

      m_txn(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
      m_txn(1'b0, 32'h0000_0040, 32'h0);
      m_txn(1'b1, 32'h0000_0000, 32'h0000_0011);
      m_txn(1'b0, 32'h0000_1000, 32'h0);
      check("alias_read", last_rd, 32'h0000_0011);

      m_txn(1'b1, 32'hF000_0000, 32'h0001_A5A5);
      check("led_a5a5", {16'h0, led}, 32'h0000_A5A5);
      m_txn(1'b0, 32'hF000_0000, 32'h0);
      sw = 16'h1234;
      m_txn(1'b0, 32'hF000_0004, 32'h0);
      check("sw_read", last_rd, 32'h0000_1234);
      m_txn(1'b1, 32'hF000_0004, 32'hFFFF_FFFF);
      m_txn(1'b0, 32'hF000_0004, 32'h0);
      m_txn(1'b1, 32'hF000_000C, 32'h0000_7777);
      m_txn(1'b0, 32'hF000_000C, 32'h0);

`ifdef MIO_TIMER_EN
      txn(1'b0, 1'b1, 32'hF000_0008, 32'hFFFF_FFFE, r, lat, e1);
      check("timer_wr_rd_hold", r, last_rd);
      txn(1'b0, 1'b0, 32'hF000_0008, 32'h0, r, lat, e2);
      check("timer_wrap", r, 32'hFFFF_FFFE + (e2 - 32'd1 - e1));
      txn(1'b0, 1'b0, 32'hF000_0008, 32'h0, r, lat, e1);
      repeat (6) @(negedge clk);
      txn(1'b0, 1'b0, 32'hF000_0008, 32'h0, r2, lat, e2);
      check("timer_delta_edges", 32'(e2 - e1), 32'd10);
      check("timer_delta", r2 - r, 32'(e2 - e1));
      last_rd = r2;
`else
      txn(1'b0, 1'b1, 32'hF000_0008, 32'hFFFF_FFFE, r, lat, e1);
      txn(1'b0, 1'b0, 32'hF000_0008, 32'h0, r, lat, e1);
      check("timer_off_read0", r, 32'h0);
      txn(1'b0, 1'b0, 32'hF000_0008, 32'h0, r, lat, e1);
      check("timer_off_read1", r, 32'h0);
      last_rd = 32'h0;
`endif

      txn(1'b1, 1'b1, 32'h0000_0000, 32'hCAFE_0001, r, lat, e1);
      check("w0_wr_latency", 32'(lat), 32'd1);
      txn(1'b1, 1'b0, 32'h0000_0000, 32'h0, r, lat, e1);
      check("w0_rd_latency", 32'(lat), 32'd1);
      check("w0_rd_data", r, 32'hCAFE_0001);
      @(negedge clk);
      cpu0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
      @(negedge clk);
      check("w0_held_ack1", {31'h0, rdy0}, 32'h1);
      @(negedge clk);
      check("w0_held_gap", {31'h0, rdy0}, 32'h0);
      check("w0_held_gap_busy", {31'h0, bsy0}, 32'h0);
      @(negedge clk);
      check("w0_held_ack2", {31'h0, rdy0}, 32'h1);
      check("w0_held_data", rd0, 32'hCAFE_0001);
      cpu0 = 1'b0;
      @(negedge clk);
      check("w0_after_drop", {31'h0, rdy0}, 32'h0);

      for (int n = 0; n < 40; n++) begin
         op  = $urandom_range(0, 4);
         idx = pool[$urandom_range(0, 7)];
         a   = $urandom;
         d   = $urandom;
         a[31:28] = 4'($urandom_range(0, 14));
         a[11:2]  = 10'(idx);
         case (op)
            0, 1: m_txn(1'b1, a, d);
            2:    m_txn(!mem_m.exists(idx), a, d);
            3: begin
               a[31:28] = 4'hF; a[3:2] = 2'd0;
               m_txn($urandom_range(0, 1) == 1, a, d);
            end
            default: begin
               sw = 16'($urandom);
               a[31:28] = 4'hF; a[3:2] = 2'd1;
               m_txn(1'b0, a, d);
            end
         endcase
      end

      m_txn(1'b0, 32'h0000_0040, 32'h0);
      @(negedge clk);
      cpu = 1'b1; we = 1'b1; addr = 32'h0000_0040; wd = 32'h0000_55AA;
      @(posedge clk);
      @(negedge clk);
      cpu = 1'b0;
      reset = 1'b1;
      #1;
      check("abort_ready", {31'h0, rdy}, 32'h0);
      check("abort_rd", rd, 32'h0);
      check("abort_led", {16'h0, led}, 32'h0);
      check("abort_busy", {31'h0, bsy}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      led_m = 16'h0; last_rd = 32'h0;
      m_txn(1'b0, 32'h0000_0040, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
